uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_tx_if.sv | 12 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/uart_tx.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_tx.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: register offsets, STATUS bit
// positions and transmitter FSM encoding, used by the I/O decoder and FSM.
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV_LO = 2'd2;
  localparam logic [1:0] REG_DIV_HI = 2'd3;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_FLAG  = 3;
  localparam int ST_OVF   = 4;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  function automatic logic [7:0] pack_status(
    input logic empty,
    input logic full,
    input logic busy,
    input logic flag,
    input logic ovf
  );
    logic [7:0] s;
    s           = '0;
    s[ST_EMPTY] = empty;
    s[ST_FULL]  = full;
    s[ST_BUSY]  = busy;
    s[ST_FLAG]  = flag;
    s[ST_OVF]   = ovf;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// I/O bus seen by the UART register block: the CPU side drives address,
// data and strobes; the UART returns registered read data.
interface uart_tx_if;
  logic [7:0]  din;
  logic [15:0] address;
  logic        w_en;
  logic        r_en;
  logic [7:0]  dout;

  modport master (output din, output address, output w_en, output r_en, input dout);
  modport slave  (input din, input address, input w_en, input r_en, output dout);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read; a push on a full
// FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Memory-mapped UART transmitter: 4-register I/O window, transmit FIFO,
// 8N1 serialiser with programmable divisor and a "drained" interrupt flag.
module uart_tx
  import uart_pkg::*;
#(
  parameter logic [15:0] BASE      = 16'h1010,
  parameter int          DEPTH     = 8,
  parameter logic [15:0] DIV_RESET = 16'd103
) (
  input  logic       clk,
  input  logic       rst,
  uart_tx_if.slave   bus,
  output logic       tx,
  output logic       tx_flag,
  input  logic       tx_flag_clr
);

  localparam logic [13:0] BLOCK = BASE[15:2];

  // Register-access decode
  logic       hit;
  logic [1:0] offset;
  logic       wr_data;
  logic       wr_status;
  logic       wr_div_lo;
  logic       wr_div_hi;
  logic       rd_hit;

  assign hit       = (bus.address[15:2] == BLOCK);
  assign offset    = bus.address[1:0];
  assign wr_data   = bus.w_en && hit && (offset == REG_DATA);
  assign wr_status = bus.w_en && hit && (offset == REG_STATUS);
  assign wr_div_lo = bus.w_en && hit && (offset == REG_DIV_LO);
  assign wr_div_hi = bus.w_en && hit && (offset == REG_DIV_HI);
  assign rd_hit    = bus.r_en && hit;

  // FIFO
  logic       fifo_pop;
  logic [7:0] fifo_rdata;
  logic       fifo_full;
  logic       fifo_empty;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_data),
    .pop   (fifo_pop),
    .wdata (bus.din),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Control registers
  logic [15:0] div_reg;
  logic        overflow_reg;
  logic        tx_flag_reg;
  logic [7:0]  dout_reg;
  logic        flag_set;
  logic [7:0]  status;

  // Serialiser state
  tx_state_t   state_reg,  state_next;
  logic [15:0] cnt_reg,    cnt_next;
  logic [2:0]  bit_reg,    bit_next;
  logic [7:0]  shift_reg,  shift_next;
  logic        tx_reg,     tx_next;
  logic        bit_done;

  assign status = pack_status(fifo_empty, fifo_full, (state_reg != IDLE),
                              tx_flag_reg, overflow_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_reg <= DIV_RESET;
    end else begin
      if (wr_div_lo) begin
        div_reg[7:0] <= bus.din;
      end
      if (wr_div_hi) begin
        div_reg[15:8] <= bus.din;
      end
    end
  end

  // A write that coincides with a pop on a full FIFO still fits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_reg <= 1'b0;
    end else if (wr_data && fifo_full && !fifo_pop) begin
      overflow_reg <= 1'b1;
    end else if (wr_status && bus.din[ST_OVF]) begin
      overflow_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_flag_reg <= 1'b0;
    end else if (flag_set) begin
      tx_flag_reg <= 1'b1;
    end else if (tx_flag_clr) begin
      tx_flag_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_reg <= '0;
    end else if (rd_hit) begin
      case (offset)
        REG_STATUS: dout_reg <= status;
        REG_DIV_LO: dout_reg <= div_reg[7:0];
        REG_DIV_HI: dout_reg <= div_reg[15:8];
        default:    dout_reg <= '0;
      endcase
    end else begin
      dout_reg <= '0;
    end
  end

  assign bus.dout = dout_reg;
  assign tx       = tx_reg;
  assign tx_flag  = tx_flag_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
    end
  end

  assign bit_done = (cnt_reg == '0);

  // The counter reloads from div_reg only at bit boundaries, so a divisor
  // write never shortens the bit currently on the line.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    tx_next    = tx_reg;
    fifo_pop   = 1'b0;
    flag_set   = 1'b0;

    case (state_reg)
      IDLE: begin
        tx_next = 1'b1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_rdata;
          cnt_next   = div_reg;
          tx_next    = 1'b0;
          state_next = START;
        end
      end

      START: begin
        if (bit_done) begin
          tx_next    = shift_reg[0];
          shift_next = {1'b0, shift_reg[7:1]};
          bit_next   = '0;
          cnt_next   = div_reg;
          state_next = DATA;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      DATA: begin
        if (bit_done) begin
          cnt_next = div_reg;
          if (bit_reg == 3'(DATA_BITS - 1)) begin
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            tx_next    = shift_reg[0];
            shift_next = {1'b0, shift_reg[7:1]};
            bit_next   = bit_reg + 1'b1;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      STOP: begin
        if (bit_done) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_next = fifo_rdata;
            cnt_next   = div_reg;
            tx_next    = 1'b0;
            state_next = START;
          end else begin
            flag_set   = 1'b1;
            cnt_next   = '0;
            tx_next    = 1'b1;
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      default: begin
        tx_next    = 1'b1;
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: register-map vector table, directed frame/flag/reset
// sequences and randomised frame streams checked against a timing model.
module tb_uart_tx;
  import uart_pkg::*;

  localparam logic [15:0] BASE  = 16'h1010;
  localparam int          DEPTH = 8;
  localparam int          HMAX  = 16384;

  logic clk = 1'b0;
  logic rst;
  logic tx;
  logic tx_flag;
  logic tx_flag_clr;

  uart_tx_if bus ();

  uart_tx #(
    .BASE      (BASE),
    .DEPTH     (DEPTH),
    .DIV_RESET (16'd103)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .tx          (tx),
    .tx_flag     (tx_flag),
    .tx_flag_clr (tx_flag_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Line history, one sample per cycle on the falling edge.
  logic tx_hist   [HMAX];
  logic flag_hist [HMAX];
  int   ncnt = 0;

  always @(negedge clk) begin
    if (ncnt < HMAX) begin
      tx_hist[ncnt]   = tx;
      flag_hist[ncnt] = tx_flag;
    end
    ncnt++;
  end

  // Model: bytes accepted, the cycle index of the edge that pushed each, divisor.
  int         base;
  logic [7:0] m_byte [$];
  int         m_k    [$];
  int         m_div;

  typedef struct {
    bit          is_wr;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  exp;
  } vec_t;
  vec_t tbl [$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus.address = a;
    bus.din     = d;
    bus.w_en    = 1'b1;
    @(posedge clk);
    #1;
    bus.w_en = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d);
    bus.address = a;
    bus.r_en    = 1'b1;
    @(posedge clk);
    #1;
    bus.r_en = 1'b0;
    d = bus.dout;
  endtask

  task automatic log_start();
    base = ncnt;
    m_byte.delete();
    m_k.delete();
  endtask

  task automatic push(input logic [7:0] b);
    m_byte.push_back(b);
    m_k.push_back(ncnt - base + 1);
    wr(BASE + 16'd0, b);
  endtask

  task automatic set_div(input int d);
    wr(BASE + 16'd2, 8'(d));
    wr(BASE + 16'd3, 8'(d >> 8));
    m_div = d;
  endtask

  task automatic clr_flag();
    tx_flag_clr = 1'b1;
    @(posedge clk);
    #1;
    tx_flag_clr = 1'b0;
  endtask

  task automatic wait_log(input int m);
    while (ncnt - base < m) begin
      @(posedge clk);
      #1;
    end
  endtask

  // A byte pushed at edge k starts on line cycle k+1, or right after the
  // previous frame if that is later; each frame lasts 10*(DIV+1) cycles.
  task automatic verify_log(input string name, input int tail);
    int   f;
    int   st [$];
    int   prev_end;
    int   fin;
    int   s;
    int   bad;
    int   bpos;
    bit   gap;
    bit   inframe;
    logic e;
    logic [7:0] cur;
    f        = 10 * (m_div + 1);
    prev_end = 0;
    gap      = 1'b0;
    for (int j = 0; j < m_byte.size(); j++) begin
      s = m_k[j] + 1;
      if (j > 0 && prev_end > s) s = prev_end;
      if (j > 0 && s != prev_end) gap = 1'b1;
      st.push_back(s);
      prev_end = s + f;
    end
    fin = prev_end + tail;
    if (base + fin >= HMAX) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: history budget exceeded (need %0d)", name, base + fin);
      return;
    end
    wait_log(fin + 1);
    for (int j = 0; j < m_byte.size(); j++) begin
      cur = m_byte[j];
      bad = -1;
      for (int c = 0; c < f; c++) begin
        bpos = c / (m_div + 1);
        if (bpos == 0)      e = 1'b0;
        else if (bpos == 9) e = 1'b1;
        else                e = cur[bpos-1];
        if (tx_hist[base + st[j] + c] !== e && bad < 0) bad = c;
      end
      n_cmp++;
      if (bad >= 0) begin
        n_bad++;
        $display("FAIL %s frame %0d byte %02h: tx wrong at cycle %0d of frame, got %b",
                 name, j, cur, bad, tx_hist[base + st[j] + bad]);
      end
    end
    bad = -1;
    for (int i = 0; i <= fin; i++) begin
      inframe = 1'b0;
      for (int j = 0; j < st.size(); j++) begin
        if (i >= st[j] && i < st[j] + f) inframe = 1'b1;
      end
      if (!inframe && tx_hist[base + i] !== 1'b1 && bad < 0) bad = i;
    end
    n_cmp++;
    if (bad >= 0) begin
      n_bad++;
      $display("FAIL %s idle: tx got 0 at cycle %0d, expected 1", name, bad);
    end
    check({name, " flag_set"}, int'(flag_hist[base + prev_end]), 1);
    if (!gap) begin
      check({name, " flag_before"}, int'(flag_hist[base + prev_end - 1]), 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rv;
    int         n;
    int         d;
    int         g;

    rst         = 1'b1;
    tx_flag_clr = 1'b0;
    bus.address = '0;
    bus.din     = '0;
    bus.w_en    = 1'b0;
    bus.r_en    = 1'b0;
    m_div       = 103;
    base        = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset tx", int'(tx), 1);
    check("reset tx_flag", int'(tx_flag), 0);
    check("reset dout", int'(bus.dout), 0);

    // Register map and address decode.
    tbl.push_back('{1'b0, BASE + 16'd1, 8'h00, 8'h01});
    tbl.push_back('{1'b0, BASE + 16'd2, 8'h00, 8'h67});
    tbl.push_back('{1'b0, BASE + 16'd3, 8'h00, 8'h00});
    tbl.push_back('{1'b0, BASE + 16'd0, 8'h00, 8'h00});
    tbl.push_back('{1'b1, BASE + 16'd2, 8'h34, 8'h00});
    tbl.push_back('{1'b1, BASE + 16'd3, 8'h12, 8'h00});
    tbl.push_back('{1'b0, BASE + 16'd2, 8'h00, 8'h34});
    tbl.push_back('{1'b0, BASE + 16'd3, 8'h00, 8'h12});
    tbl.push_back('{1'b0, BASE + 16'd1, 8'h00, 8'h01});
    tbl.push_back('{1'b0, BASE + 16'd4, 8'h00, 8'h00});
    tbl.push_back('{1'b1, BASE + 16'd4, 8'h77, 8'h00});
    tbl.push_back('{1'b1, BASE - 16'd1, 8'h88, 8'h00});
    tbl.push_back('{1'b1, 16'h2012,     8'h99, 8'h00});
    tbl.push_back('{1'b0, BASE + 16'd1, 8'h00, 8'h01});
    tbl.push_back('{1'b0, BASE - 16'd1, 8'h00, 8'h00});
    tbl.push_back('{1'b0, BASE + 16'd3, 8'h00, 8'h12});
    tbl.push_back('{1'b0, BASE + 16'd2, 8'h00, 8'h34});
    tbl.push_back('{1'b0, 16'h2012,     8'h00, 8'h00});
    tbl.push_back('{1'b1, BASE + 16'd1, 8'hFF, 8'h00});
    tbl.push_back('{1'b0, BASE + 16'd1, 8'h00, 8'h01});
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].is_wr) begin
        wr(tbl[i].addr, tbl[i].data);
        rv = bus.dout;
      end else begin
        rd(tbl[i].addr, rv);
      end
      $display("vec %0d %s addr=%04h din=%02h dout=%02h", i,
               tbl[i].is_wr ? "WR" : "RD", tbl[i].addr, tbl[i].data, rv);
      check($sformatf("vec%0d", i), int'(rv), int'(tbl[i].exp));
    end
    @(posedge clk);
    #1;
    check("dout idle zero", int'(bus.dout), 0);

    // Test 1: single frame of A5 at DIV=3.
    set_div(3);
    log_start();
    push(8'hA5);
    verify_log("t1", 8);
    $display("t1 frame A5 div=3 done");

    // Test 2: nine back-to-back writes from idle.
    clr_flag();
    log_start();
    for (int i = 0; i < 9; i++) push(8'(8'h30 + i));
    rd(BASE + 16'd1, rv);
    check("t2 status full busy", int'(rv), 8'h06);
    verify_log("t2", 80);
    rd(BASE + 16'd1, rv);
    check("t2 status drained", int'(rv), 8'h09);
    $display("t2 nine frames done");

    // Test 3: push on the pop cycle succeeds; the next push on full is dropped.
    set_div(20);
    clr_flag();
    log_start();
    for (int i = 0; i < 9; i++) push(8'($urandom));
    wait_log(2 + 210 - 1);
    push(8'h3C);
    wr(BASE + 16'd0, 8'h55);
    rd(BASE + 16'd1, rv);
    check("t3 status overflow", int'(rv), 8'h16);
    wr(BASE + 16'd1, 8'h10);
    rd(BASE + 16'd1, rv);
    check("t3 status ovf cleared", int'(rv), 8'h06);
    verify_log("t3", 420);
    rd(BASE + 16'd1, rv);
    check("t3 status drained", int'(rv), 8'h09);
    $display("t3 overflow sequence done");

    // Test 4: clear coincident with set loses to set; lone clear works.
    set_div(2);
    clr_flag();
    check("t4 flag cleared", int'(tx_flag), 0);
    log_start();
    push(8'h81);
    wait_log(2 + 30 - 1);
    check("t4 flag before set", int'(tx_flag), 0);
    tx_flag_clr = 1'b1;
    @(posedge clk);
    #1;
    tx_flag_clr = 1'b0;
    check("t4 set wins over clr", int'(tx_flag), 1);
    clr_flag();
    check("t4 clr alone", int'(tx_flag), 0);
    $display("t4 flag priority done");

    // Test 5: reset during data bit 3 of the first of three queued frames.
    set_div(3);
    log_start();
    push(8'h00);
    push(8'hFF);
    push(8'hF0);
    wait_log(2 + 4 * 4 + 1);
    check("t5 tx low in bit3", int'(tx), 0);
    #2;
    rst = 1'b1;
    #1;
    check("t5 async tx high", int'(tx), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rd(BASE + 16'd1, rv);
    check("t5 status after rst", int'(rv), 8'h01);
    rd(BASE + 16'd2, rv);
    check("t5 div lo", int'(rv), 103);
    rd(BASE + 16'd3, rv);
    check("t5 div hi", int'(rv), 0);
    m_div = 103;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1) n++;
    end
    check("t5 queue discarded", n, 0);
    $display("t5 reset abort done");

    // Randomised streams with and without gaps between writes.
    for (int r = 0; r < 6; r++) begin
      d = (r == 0) ? 0 : int'($urandom_range(0, 4));
      set_div(d);
      clr_flag();
      log_start();
      n = int'($urandom_range(1, 9));
      for (int j = 0; j < n; j++) begin
        g = (r % 2 == 1) ? int'($urandom_range(0, 12)) : 0;
        repeat (g) begin
          @(posedge clk);
          #1;
        end
        push(8'($urandom));
      end
      verify_log($sformatf("rnd%0d", r), 2 * 10 * (d + 1) + 2);
      rd(BASE + 16'd1, rv);
      check($sformatf("rnd%0d status", r), int'(rv), 8'h09);
      $display("rnd %0d div=%0d bytes=%0d done", r, d, n);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
